// File: rtl/avalon_gpio.sv
// Avalon-MM GPIO slave: synchronized inputs with rising-edge capture and a
// maskable level interrupt, plus a registered output port with atomic set/clear.
module avalon_gpio #(
    parameter int unsigned    IN_W      = 10,
    parameter int unsigned    OUT_W     = 10,
    parameter logic [OUT_W-1:0] OUT_RESET = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq,
    input  logic [IN_W-1:0]   gpio_in,
    output logic [OUT_W-1:0]  gpio_out
);

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] A_DATA_IN  = 3'd0;
    localparam logic [2:0] A_DATA_OUT = 3'd1;
    localparam logic [2:0] A_SET      = 3'd2;
    localparam logic [2:0] A_CLR      = 3'd3;
    localparam logic [2:0] A_MASK     = 3'd4;
    localparam logic [2:0] A_EDGE_CAP = 3'd5;

    logic [IN_W-1:0]   s1_q, s1_d;
    logic [IN_W-1:0]   s2_q, s2_d;
    logic [IN_W-1:0]   s3_q, s3_d;
    logic [IN_W-1:0]   cap_q, cap_d;
    logic [IN_W-1:0]   mask_q, mask_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [IN_W-1:0]   wd_in_c;
    logic [OUT_W-1:0]  wd_out_c;
    logic [IN_W-1:0]   rise_c;
    logic [IN_W-1:0]   clr_c;
    logic              wdata_unused_c;

    assign wd_in_c        = avs_writedata[IN_W-1:0];
    assign wd_out_c       = avs_writedata[OUT_W-1:0];
    assign wdata_unused_c = ^avs_writedata;

    // Three-flop input chain; s3 only exists to detect edges on s2.
    always_comb begin
        s1_d   = gpio_in;
        s2_d   = s1_q;
        s3_d   = s2_q;
        rise_c = s2_q & ~s3_q;
    end

    // Output register: direct write, atomic set and atomic clear.
    always_comb begin
        out_d = out_q;
        if (avs_write) begin
            case (avs_address)
                A_DATA_OUT: out_d = wd_out_c;
                A_SET:      out_d = out_q | wd_out_c;
                A_CLR:      out_d = out_q & ~wd_out_c;
                default:    out_d = out_q;
            endcase
        end
    end

    // Mask register and edge capture; a new rise beats a same-cycle W1C.
    always_comb begin
        mask_d = mask_q;
        clr_c  = '0;
        if (avs_write && (avs_address == A_MASK)) begin
            mask_d = wd_in_c;
        end
        if (avs_write && (avs_address == A_EDGE_CAP)) begin
            clr_c = wd_in_c;
        end
        cap_d = (cap_q & ~clr_c) | rise_c;
        irq_d = |(cap_q & mask_q);
    end

    // Read mux samples pre-write register state; holds when no read.
    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            case (avs_address)
                A_DATA_IN:  rdata_d = DATA_W'(s2_q);
                A_DATA_OUT: rdata_d = DATA_W'(out_q);
                A_MASK:     rdata_d = DATA_W'(mask_q);
                A_EDGE_CAP: rdata_d = DATA_W'(cap_q);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            cap_q   <= '0;
            mask_q  <= '0;
            out_q   <= OUT_RESET;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            cap_q   <= cap_d;
            mask_q  <= mask_d;
            out_q   <= out_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
    assign gpio_out     = out_q;

endmodule

// File: tb/tb_avalon_gpio.sv
// Self-checking bench for avalon_gpio: directed register-map scenarios followed
// by random bus traffic, all compared against a register-level reference model.
module tb_avalon_gpio;

    localparam int unsigned IN_W  = 10;
    localparam int unsigned OUT_W = 10;
    localparam logic [OUT_W-1:0] OUT_RST = 10'h155;

    logic              clk;
    logic              reset_n;
    logic [2:0]        addr;
    logic              rd;
    logic              wr;
    logic [31:0]       wdata;
    logic [31:0]       avs_readdata;
    logic              irq;
    logic [IN_W-1:0]   gin;
    logic [OUT_W-1:0]  gpio_out;

    avalon_gpio #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .OUT_RESET (OUT_RST)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (addr),
        .avs_read      (rd),
        .avs_write     (wr),
        .avs_writedata (wdata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .gpio_in       (gin),
        .gpio_out      (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h required 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: register file plus history of gpio_in as sampled at
    // each edge (smp[0] = most recent sample, smp[1] = the one before, ...).
    logic [IN_W-1:0]  smp [3];
    logic [OUT_W-1:0] m_out;
    logic [IN_W-1:0]  m_mask;
    logic [IN_W-1:0]  m_cap;
    logic             m_irq;
    logic [31:0]      m_rd;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) smp[i] = '0;
        m_out  = OUT_RST;
        m_mask = '0;
        m_cap  = '0;
        m_irq  = 1'b0;
        m_rd   = '0;
    endfunction

    // Advance the model by one clock edge using the inputs now presented.
    function automatic void model_edge();
        logic [IN_W-1:0]  data_in;
        logic [IN_W-1:0]  new_edges;
        logic [IN_W-1:0]  cleared;
        logic [OUT_W-1:0] nxt_out;
        logic [IN_W-1:0]  nxt_mask;
        data_in   = smp[1];
        new_edges = smp[1] & ~smp[2];
        cleared   = (wr && addr == 3'd5) ? wdata[IN_W-1:0] : '0;
        if (rd) begin
            case (addr)
                3'd0:    m_rd = 32'(data_in);
                3'd1:    m_rd = 32'(m_out);
                3'd4:    m_rd = 32'(m_mask);
                3'd5:    m_rd = 32'(m_cap);
                default: m_rd = 32'h0;
            endcase
        end
        nxt_out  = m_out;
        nxt_mask = m_mask;
        if (wr) begin
            if (addr == 3'd1) nxt_out = wdata[OUT_W-1:0];
            if (addr == 3'd2) nxt_out = m_out | wdata[OUT_W-1:0];
            if (addr == 3'd3) nxt_out = m_out & ~wdata[OUT_W-1:0];
            if (addr == 3'd4) nxt_mask = wdata[IN_W-1:0];
        end
        m_irq  = (m_cap & m_mask) != '0;
        m_cap  = (m_cap & ~cleared) | new_edges;
        m_out  = nxt_out;
        m_mask = nxt_mask;
        smp[2] = smp[1];
        smp[1] = smp[0];
        smp[0] = gin;
    endfunction

    // One clock with current inputs, then compare every output on the falling edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_eq("gpio_out", 32'(gpio_out), 32'(m_out));
        check_eq("irq", 32'(irq), 32'(m_irq));
        check_eq("readdata", avs_readdata, m_rd);
    endtask

    task automatic bus(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        rd    = r;
        wr    = w;
        addr  = a;
        wdata = d;
        tick();
        rd    = 1'b0;
        wr    = 1'b0;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    int unsigned rsel;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = 3'd0; wdata = 32'h0; gin = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("in_reset_out", 32'(gpio_out), 32'h155);
        reset_n = 1'b1;

        // Reset state
        idle();
        check_eq("rst_gpio_out", 32'(gpio_out), 32'h155);
        check_eq("rst_irq", 32'(irq), 32'h0);
        bus(1'b1, 1'b0, 3'd0, 32'h0); check_eq("rst_rd0", avs_readdata, 32'h0);
        bus(1'b1, 1'b0, 3'd4, 32'h0); check_eq("rst_rd4", avs_readdata, 32'h0);
        bus(1'b1, 1'b0, 3'd5, 32'h0); check_eq("rst_rd5", avs_readdata, 32'h0);

        // Output register write / set / clear
        bus(1'b0, 1'b1, 3'd1, 32'h0F0); check_eq("wr_out", 32'(gpio_out), 32'h0F0);
        bus(1'b0, 1'b1, 3'd2, 32'h003); check_eq("set_out", 32'(gpio_out), 32'h0F3);
        bus(1'b0, 1'b1, 3'd3, 32'h010); check_eq("clr_out", 32'(gpio_out), 32'h0E3);
        bus(1'b1, 1'b0, 3'd1, 32'h0);   check_eq("rd_out", avs_readdata, 32'h0E3);
        bus(1'b1, 1'b0, 3'd2, 32'h0);   check_eq("rd_set", avs_readdata, 32'h0);
        bus(1'b1, 1'b0, 3'd1, 32'h0);
        bus(1'b1, 1'b0, 3'd3, 32'h0);   check_eq("rd_clr", avs_readdata, 32'h0);

        // Edge capture and interrupt latency
        bus(1'b0, 1'b1, 3'd4, 32'h001);
        gin = 10'h201;
        idle(); idle(); idle();
        check_eq("irq_k2", 32'(irq), 32'h0);
        idle();
        check_eq("irq_k3", 32'(irq), 32'h1);
        bus(1'b1, 1'b0, 3'd0, 32'h0); check_eq("rd_din", avs_readdata, 32'h201);
        bus(1'b1, 1'b0, 3'd5, 32'h0); check_eq("rd_cap", avs_readdata, 32'h201);

        // W1C clear, then W1C colliding with a fresh rise
        bus(1'b0, 1'b1, 3'd5, 32'h001);
        bus(1'b1, 1'b0, 3'd5, 32'h0);
        check_eq("w1c_cap", avs_readdata, 32'h200);
        check_eq("w1c_irq", 32'(irq), 32'h0);
        gin = 10'h200;
        idle(); idle(); idle(); idle();
        gin = 10'h201;
        idle(); idle();
        bus(1'b0, 1'b1, 3'd5, 32'h001);
        bus(1'b1, 1'b0, 3'd5, 32'h0);
        check_eq("setwins_cap", avs_readdata, 32'h201);
        check_eq("setwins_irq", 32'(irq), 32'h1);

        // Back-to-back reads, wide write, read+write collision
        bus(1'b1, 1'b0, 3'd0, 32'h0); check_eq("b2b_0", avs_readdata, 32'h201);
        bus(1'b1, 1'b0, 3'd1, 32'h0); check_eq("b2b_1", avs_readdata, 32'h0E3);
        bus(1'b1, 1'b0, 3'd4, 32'h0); check_eq("b2b_4", avs_readdata, 32'h001);
        bus(1'b1, 1'b0, 3'd6, 32'h0); check_eq("b2b_6", avs_readdata, 32'h0);
        bus(1'b0, 1'b1, 3'd4, 32'hFFFF_FFFF);
        bus(1'b1, 1'b0, 3'd4, 32'h0); check_eq("mask_trunc", avs_readdata, 32'h3FF);
        bus(1'b1, 1'b1, 3'd1, 32'h055);
        check_eq("rw_old", avs_readdata, 32'h0E3);
        check_eq("rw_new", 32'(gpio_out), 32'h055);

        // Asynchronous reset mid-cycle with capture pending and a read in flight
        rd = 1'b1; addr = 3'd5;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_eq("arst_out", 32'(gpio_out), 32'h155);
        check_eq("arst_irq", 32'(irq), 32'h0);
        check_eq("arst_rdata", avs_readdata, 32'h0);
        rd = 1'b0;
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        bus(1'b1, 1'b0, 3'd5, 32'h0); check_eq("arst_cap", avs_readdata, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) gin = IN_W'($urandom);
            rsel = $urandom_range(0, 9);
            bus(rsel < 4 || rsel == 9, (rsel >= 4 && rsel < 8) || rsel == 9,
                3'($urandom_range(0, 7)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_gpio.md
# avalon_gpio

Avalon-MM slave GPIO peripheral that sits inside `cpu_system` as the responder to the Nios-II data master. It replaces the stock PIO pair that carries `sw` into the system and `ledr` out of it. The block provides:
- a synchronized input port with rising-edge capture and a maskable interrupt;
- a registered output port with atomic set and clear.

Reads have a fixed latency of 1 cycle, and the block never asserts waitrequest.

## Interface
Parameters:
- `IN_W`, 10, width of `gpio_in` (1..32).
- `OUT_W`, 10, width of `gpio_out` (1..32).
- `OUT_RESET`, 0, value loaded into the output register on reset (`OUT_W` bits).

Ports:
- `clk`  in  1  single system clock (driven by `clock_50` through `clk_clk`).
- `reset_n`  in  1  asynchronous, active-low reset.
- `avs_address`  in  3  word address.
- `avs_read`  in  1  read strobe, one cycle per transfer.
- `avs_write`  in  1  write strobe, one cycle per transfer.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data, valid the cycle after `avs_read`.
- `irq`  out  1  level interrupt to the CPU, registered.
- `gpio_in`  in  `IN_W`  asynchronous inputs (switches).
- `gpio_out`  out  `OUT_W`  registered outputs (LEDs).

## Operation
Register map (word addresses):
- 0 DATA_IN (RO): synchronized input `s2`, zero-extended.
- 1 DATA_OUT (RW): output register `out_q`, which drives `gpio_out`.
- 2 SET (WO): `out_q <= out_q | wd`. Reads return 0.
- 3 CLR (WO): `out_q <= out_q & ~wd`. Reads return 0.
- 4 IRQ_MASK (RW): `mask_q`, `IN_W` bits.
- 5 EDGE_CAP (RW1C): `cap_q`, `IN_W` bits. Writing 1 to a bit clears it.
- 6, 7: reserved. Reads return 0; writes are ignored.

Input path:
- Three-flop chain `s1 <= gpio_in`, `s2 <= s1`, `s3 <= s2`.
- Combinational `rise = s2 & ~s3`.
- Each clock: `cap_q <= (cap_q & ~clr) | rise`, where `clr` is `wd[IN_W-1:0]` when writing address 5 and 0 otherwise.
- A rise and a W1C on the same bit in the same cycle leave the bit set (set wins).

Interrupt: `irq <= |(cap_q & mask_q)`, registered.

Width rules:
- Write data bits above the target register width are ignored.
- Reads zero-extend to 32 bits.
- `wd` denotes `avs_writedata` truncated to the target register width.

Read path:
- On a cycle with `avs_read`, the selected value is registered into `avs_readdata`.
- Otherwise `avs_readdata` holds its last value.

Read and write in the same cycle (a protocol violation, but defined here):
- The write takes effect.
- The read returns the value from before the write.

Reset (asynchronous, any time, including mid-transfer):
- `s1`, `s2`, `s3`, `cap_q`, `mask_q`, `avs_readdata` and `irq` go to 0.
- `out_q` goes to `OUT_RESET`.
- A read in flight at reset produces no response.

## Timing
- Write: applied at the rising edge that samples `avs_write`. `gpio_out`, `mask_q` and `cap_q` show the new value immediately after that edge.
- Read: `avs_readdata` is valid after the edge that samples `avs_read` (readLatency = 1, no waitrequest). A read in cycle N returns register contents as they stood before edge N.
- Input latency, for a `gpio_in` change that meets setup at edge k:
  - `s1` at k;
  - `s2` at k+1 (DATA_IN readable from a read issued in cycle k+2);
  - `cap_q` bit set at k+2;
  - `irq` asserted at k+3 if the bit is unmasked.
- Pulses shorter than one clock may be missed; no minimum pulse detection is provided.
- Interrupt clear: a W1C write at edge m clears `cap_q` at m, and `irq` deasserts at m+1 unless another unmasked rise arrived.
- Back-to-back transfers: one read or one write per cycle, sustained, with no bubbles.

## Test plan
- Reset with `OUT_RESET`=0x155 held, then released → `gpio_out`=0x155, `irq`=0, and reads of addresses 0, 4, 5 return 0.
- Write 0x0F0 to address 1, then SET 0x003, then CLR 0x010 → `gpio_out` becomes 0x0F0, then 0x0F3, then 0x0E3, each one cycle after its write. A read of address 1 returns 0x0E3, and reads of addresses 2 and 3 return 0.
- Drive `gpio_in` from 0x000 to 0x201 at edge k with mask=0x001 → `cap_q`=0x201 at k+2, `irq`=1 at k+3. A read of address 0 returns 0x201.
- W1C 0x001 to address 5 → `cap_q`=0x200 and `irq`=0 on the next cycle. A repeated W1C 0x001 coinciding with a new rise on bit 0 leaves `cap_q` bit 0 set and `irq` staying 1.
- Issue back-to-back reads of addresses 0, 1, 4, 6 → four consecutive `avs_readdata` values, each one cycle after its read, with address 6 returning 0. Also write `writedata`=0xFFFF_FFFF to address 4 → read-back 0x3FF.
- Assert `reset_n` low asynchronously mid-cycle while `cap_q` is nonzero and a read is in flight → all state clears immediately, with no clock edge required, and `gpio_out`=`OUT_RESET`.
